frame_tx_scheduler: RTL and testbench
=====================================

Name: frame_tx_scheduler

Overview:
- Sequences one captured video frame into the USB FIFO output stage.
- Emits one header word, then FRAME_WORDS pixel words from the pixel FIFO, then one trailer word.
- Gates every transfer on FIFO-chip space (txe_n) and on pixel availability.
- Sits between the capture pixel FIFO (first-word-fall-through) and the output stage: drives its data_in and counter inputs.

Parameters:
- FRAME_WORDS, 2073600, pixel words per frame (1920x1080); legal range 1..2^21-1.
- BURST_MAX, 1024, maximum consecutive pixel transfers before one forced gap cycle (matches the 4 KB FIFO-chip buffer).
- HDR_TAG, 16'hA5A5, upper half of the header word.
- TRL_TAG, 8'h5A, top byte of the trailer word.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- frame_id  in  16  frame number; latched when start is accepted.
- pix_data  in  32  pixel FIFO head word (FWFT).
- pix_empty  in  1  pixel FIFO empty.
- pix_rd  out  1  pixel FIFO pop (combinational).
- txe_n  in  1  FIFO-chip transmit space; low = room available.
- out_data  out  32  word to the output stage (registered).
- out_valid  out  1  out_data is valid this cycle (registered).
- out_be  out  4  byte enables; 4'hF when out_valid, else 4'h0.
- word_cnt  out  21  pixel words sent in the current frame.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the trailer has been issued.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-frame:
  - state=IDLE, pix_rd=0 combinationally from the next cycle.
  - out_data=0, out_valid=0, out_be=0, word_cnt=0, busy=0, done=0, burst counter=0.
  - The partial frame is abandoned; no trailer is sent.
- States: IDLE, HDR, PIX, GAP, TRL, DONE.
- Transfer rule: in HDR/PIX/TRL a word is transferred at edge k when its conditions hold. out_valid=1 and out_data=word at edge k+1; otherwise out_valid=0 at k+1. Latency is one cycle.
- IDLE:
  - start=1 latches frame_id, clears word_cnt and the burst counter, then goes to HDR.
  - start in any other state is ignored.
- HDR:
  - Transfers {HDR_TAG, frame_id} when txe_n=0, then goes to PIX.
  - txe_n=1 holds the state.
- PIX:
  - pix_rd = (state==PIX) & ~txe_n & ~pix_empty.
  - Each transfer sends pix_data, increments word_cnt and increments the burst counter.
  - Stalls (txe_n=1 or pix_empty=1) hold all counters; no pop and no output.
  - If a transfer makes word_cnt==FRAME_WORDS, go to TRL. This takes priority over GAP.
  - Else if the burst counter reaches BURST_MAX, go to GAP.
- GAP:
  - Exactly one cycle with no transfer; clears the burst counter, then returns to PIX.
- TRL:
  - Transfers {TRL_TAG, 3'b000, word_cnt} when txe_n=0, then goes to DONE.
- DONE:
  - One cycle; done=1 (registered, so it coincides with the trailer's out_valid cycle).
  - busy stays 1, then IDLE.
  - start in DONE is ignored.
- word_cnt:
  - Holds its final value in IDLE until the next accepted start.
  - Never wraps: FRAME_WORDS ≤ 2^21-1 is guaranteed by the parameter range.
- Simultaneous txe_n rise and pix_empty: no transfer; the next transfer occurs on the first cycle both are clear.
- pix_rd is never asserted outside PIX, and never when pix_empty=1.

Test Plan:
Bench uses FRAME_WORDS=8, BURST_MAX=4, txe_n=0 unless stated.
- Nominal frame: start with frame_id=16'h0003, FIFO holding words 1..8.
  - out_valid sequence: A5A50003, 1,2,3,4, gap, 5,6,7,8, 5A000008.
  - done pulses with the trailer; 11 active cycles from start to done.
- txe_n back-pressure: hold txe_n=1 for 5 cycles after the 2nd pixel.
  - pix_rd=0 and out_valid=0 throughout the stall.
  - Resumes with pixel 3; no word lost or duplicated; word_cnt ends at 8.
- FIFO underflow: pix_empty=1 for 3 cycles mid-burst.
  - Same stall behaviour; the burst counter is not advanced by the stall.
  - The gap still follows the 4th transferred pixel.
- Reset mid-frame: assert rst after pixel 5.
  - Next cycle: out_valid=0, busy=0, word_cnt=0, no trailer.
  - A following start sends a fresh header.
- Start while busy: pulse start during PIX and during DONE.
  - Ignored; exactly one header/trailer pair per accepted start.
- Header stall: txe_n=1 for 4 cycles after start.
  - Header appears one cycle after txe_n falls; pix_rd stays 0 until the header has transferred.

Source files
------------

// File: rtl/frame_tx_scheduler.sv
// Frame transmit scheduler: sends a header word, FRAME_WORDS pixel words from a
// FWFT pixel FIFO, then a trailer word. Every word is gated on FIFO-chip space.
module frame_tx_scheduler #(
  parameter int          FRAME_WORDS = 2073600,
  parameter int          BURST_MAX   = 1024,
  parameter logic [15:0] HDR_TAG     = 16'hA5A5,
  parameter logic [7:0]  TRL_TAG     = 8'h5A
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] frame_id,
  input  logic [31:0] pix_data,
  input  logic        pix_empty,
  output logic        pix_rd,
  input  logic        txe_n,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [3:0]  out_be,
  output logic [20:0] word_cnt,
  output logic        busy,
  output logic        done
);

  localparam int                 BURST_W    = $clog2(BURST_MAX + 1);
  localparam logic [20:0]        FRAME_LAST = 21'(FRAME_WORDS);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX);
  localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PIX,
    S_GAP,
    S_TRL,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [15:0]        frame_id_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic [20:0]        word_cnt_reg;
  logic [20:0]        word_cnt_next;
  logic [BURST_W-1:0] burst_cnt_next;

  // Pop only when the word can actually leave this cycle.
  assign pix_rd         = (state_reg == S_PIX) & ~txe_n & ~pix_empty;
  assign word_cnt_next  = word_cnt_reg + 21'd1;
  assign burst_cnt_next = burst_cnt_reg + BURST_ONE;
  assign busy           = (state_reg != S_IDLE);
  assign word_cnt       = word_cnt_reg;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      frame_id_reg  <= 16'h0000;
      burst_cnt_reg <= '0;
      word_cnt_reg  <= 21'd0;
      out_data      <= 32'h0000_0000;
      out_valid     <= 1'b0;
      out_be        <= 4'h0;
      done          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_be    <= 4'h0;
      done      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            frame_id_reg  <= frame_id;
            word_cnt_reg  <= 21'd0;
            burst_cnt_reg <= '0;
            state_reg     <= S_HDR;
          end
        end
        S_HDR: begin
          if (!txe_n) begin
            out_data  <= {HDR_TAG, frame_id_reg};
            out_valid <= 1'b1;
            out_be    <= 4'hF;
            state_reg <= S_PIX;
          end
        end
        S_PIX: begin
          if (pix_rd) begin
            out_data      <= pix_data;
            out_valid     <= 1'b1;
            out_be        <= 4'hF;
            word_cnt_reg  <= word_cnt_next;
            burst_cnt_reg <= burst_cnt_next;
            // End of frame wins over the burst gap.
            if (word_cnt_next == FRAME_LAST) begin
              state_reg <= S_TRL;
            end else if (burst_cnt_next == BURST_LAST) begin
              state_reg <= S_GAP;
            end
          end
        end
        S_GAP: begin
          burst_cnt_reg <= '0;
          state_reg     <= S_PIX;
        end
        S_TRL: begin
          if (!txe_n) begin
            out_data  <= {TRL_TAG, 3'b000, word_cnt_reg};
            out_valid <= 1'b1;
            out_be    <= 4'hF;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Scoreboard bench for frame_tx_scheduler with an 8-word frame and 4-word bursts.
module tb_frame_tx_scheduler;

  logic        CLK = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] frame_id;
  logic [31:0] pix_data;
  logic        pix_empty;
  logic        pix_rd;
  logic        txe_n;
  logic [31:0] out_data;
  logic        out_valid;
  logic [3:0]  out_be;
  logic [20:0] word_cnt;
  logic        busy;
  logic        done;

  int          checks   = 0;
  int          failures = 0;
  int          pix_pops = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] sb_q[$];
  bit          vlog[$];
  logic [31:0] dlog[$];
  bit          force_empty;
  logic        rd_last;

  always #5 CLK = ~CLK;

  frame_tx_scheduler #(
    .FRAME_WORDS(8),
    .BURST_MAX  (4),
    .HDR_TAG    (16'hA5A5),
    .TRL_TAG    (8'h5A)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .start    (start),
    .frame_id (frame_id),
    .pix_data (pix_data),
    .pix_empty(pix_empty),
    .pix_rd   (pix_rd),
    .txe_n    (txe_n),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_be   (out_be),
    .word_cnt (word_cnt),
    .busy     (busy),
    .done     (done)
  );

  task automatic refresh();
    pix_empty = force_empty || (fifo_q.size() == 0);
    pix_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endtask

  // One clock: sample pix_rd before the edge, then model the FIFO pop and
  // score the registered outputs just after the edge.
  task automatic cycle();
    logic [31:0] exp_w;
    logic [31:0] junk;
    @(negedge CLK);
    rd_last = pix_rd;
    checks++;
    if (rd_last === 1'b1 && (pix_empty || txe_n)) begin
      failures++;
      $display("FAIL pix_rd_gate: pix_rd=1 with pix_empty=%0b txe_n=%0b, required pix_rd=0", pix_empty, txe_n);
    end
    @(posedge CLK);
    #1;
    if (rd_last === 1'b1) begin
      if (fifo_q.size() != 0) junk = fifo_q.pop_front();
      pix_pops++;
    end
    refresh();
    checks++;
    if (out_be !== ((out_valid === 1'b1) ? 4'hF : 4'h0)) begin
      failures++;
      $display("FAIL out_be: got %h with out_valid=%b", out_be, out_valid);
    end
    vlog.push_back(out_valid === 1'b1);
    dlog.push_back(out_data);
    if (out_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word: got %h, required no output", out_data);
      end else begin
        exp_w = sb_q.pop_front();
        if (out_data !== exp_w) begin
          failures++;
          $display("FAIL out_data: got %h, required %h", out_data, exp_w);
        end else begin
          $display("word %h ok (word_cnt=%0d)", out_data, word_cnt);
        end
      end
    end
  endtask

  task automatic load_frame(input logic [15:0] fid, input logic [31:0] base);
    sb_q.push_back({16'hA5A5, fid});
    for (int i = 1; i <= 8; i++) begin
      fifo_q.push_back(base + 32'(i));
      sb_q.push_back(base + 32'(i));
    end
    sb_q.push_back(32'h5A00_0008);
    refresh();
  endtask

  task automatic do_start(input logic [15:0] fid);
    pix_pops = 0;
    vlog.delete();
    dlog.delete();
    frame_id = fid;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
    frame_id = 16'hFFFF;
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while (pix_pops < target && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (pix_pops < target) begin
      failures++;
      $display("FAIL %s_timeout: pops=%0d, required %0d", tag, pix_pops, target);
    end
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout: done=%b, required 1", tag, done);
    end
    cycle();
    checks++;
    if (busy !== 1'b0 || word_cnt !== 21'd8 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_end: busy=%b word_cnt=%0d pending=%0d, required 0/8/0", tag, busy, word_cnt, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 21'd0 || done !== 1'b0 || pix_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b cnt=%0d done=%b rd=%b, required all 0",
               out_valid, busy, word_cnt, done, pix_rd);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_nominal();
    logic [13:0] val_bits;
    logic [13:0] done_bits;
    load_frame(16'h0003, 32'h0);
    do_start(16'h0003);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL nominal_busy: busy=%b, required 1", busy);
    end
    vlog.delete();
    for (int i = 0; i < 14; i++) begin
      cycle();
      done_bits[i] = (done === 1'b1);
      val_bits[i]  = vlog[i];
    end
    checks++;
    if (val_bits !== 14'h07DF) begin
      failures++;
      $display("FAIL nominal_valid_seq: got %b, required %b", val_bits, 14'h07DF);
    end
    checks++;
    if (done_bits !== 14'h0400) begin
      failures++;
      $display("FAIL nominal_done_seq: got %b, required %b", done_bits, 14'h0400);
    end
    checks++;
    if (busy !== 1'b0 || word_cnt !== 21'd8 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL nominal_end: busy=%b word_cnt=%0d pending=%0d, required 0/8/0", busy, word_cnt, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    load_frame(16'h0010, 32'h100);
    do_start(16'h0010);
    wait_pops(2, "bp");
    txe_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (rd_last !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall: pix_rd=%b out_valid=%b, required 0/0", rd_last, out_valid);
      end
    end
    txe_n = 1'b0;
    run_to_done("bp");
  endtask

  task automatic test_underflow();
    int j = -1;
    load_frame(16'h0020, 32'h200);
    do_start(16'h0020);
    wait_pops(2, "uf");
    force_empty = 1'b1;
    refresh();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (rd_last !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL uf_stall: pix_rd=%b out_valid=%b, required 0/0", rd_last, out_valid);
      end
    end
    force_empty = 1'b0;
    refresh();
    run_to_done("uf");
    for (int i = 0; i < vlog.size(); i++) begin
      if (j < 0 && vlog[i] && dlog[i] == 32'h204) j = i;
    end
    checks++;
    if (j < 0 || j + 2 >= vlog.size()) begin
      failures++;
      $display("FAIL uf_gap_find: pixel 4 index=%0d, required a pixel 4 followed by two cycles", j);
    end else if (vlog[j+1] || !vlog[j+2] || dlog[j+2] !== 32'h205) begin
      failures++;
      $display("FAIL uf_gap: after pixel 4 valid=%b then %b/%h, required 0 then 1/00000205",
               vlog[j+1], vlog[j+2], dlog[j+2]);
    end
  endtask

  task automatic test_reset_midframe();
    load_frame(16'h0030, 32'h300);
    do_start(16'h0030);
    wait_pops(5, "rstmid");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 21'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state: valid=%b busy=%b cnt=%0d done=%b, required all 0", out_valid, busy, word_cnt, done);
    end
    sb_q.delete();
    fifo_q.delete();
    refresh();
    for (int i = 0; i < 6; i++) cycle();
    load_frame(16'h0031, 32'h380);
    do_start(16'h0031);
    run_to_done("rstmid");
  endtask

  task automatic test_start_busy();
    int n = 0;
    load_frame(16'h0040, 32'h400);
    do_start(16'h0040);
    wait_pops(3, "sb");
    start    = 1'b1;
    frame_id = 16'h0099;
    cycle();
    start    = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL sb_done_timeout: done=%b, required 1", done);
    end
    start    = 1'b1;
    frame_id = 16'h0077;
    cycle();
    start    = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    checks++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_ignored: busy=%b pending=%0d, required 0/0", busy, sb_q.size());
    end
  endtask

  task automatic test_header_stall();
    load_frame(16'h0050, 32'h500);
    txe_n = 1'b1;
    do_start(16'h0050);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || rd_last !== 1'b0) begin
        failures++;
        $display("FAIL hdr_stall: out_valid=%b pix_rd=%b, required 0/0", out_valid, rd_last);
      end
    end
    txe_n = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || rd_last !== 1'b0) begin
      failures++;
      $display("FAIL hdr_release: out_valid=%b pix_rd=%b, required 1/0", out_valid, rd_last);
    end
    run_to_done("hdr");
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    frame_id    = 16'h0000;
    txe_n       = 1'b0;
    force_empty = 1'b0;
    rd_last     = 1'b0;
    refresh();
    test_reset();
    test_nominal();
    test_backpressure();
    test_underflow();
    test_reset_midframe();
    test_start_busy();
    test_header_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
